parity_frame_ctrl: RTL and testbench

//   Sequencer wrapped around the combinational parity generator. Accepts one

---
 rtl/parity_frame_ctrl.sv | 120 ++++++++++++
 tb/tb_parity_frame_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_ctrl.sv
// Serialises one DATA_W-bit word per handshake LSB first, appends an even/odd
// parity bit, then optionally idles for GAP_CYC cycles before the next frame.
module parity_frame_ctrl #(
  parameter int unsigned DATA_W  = 3,
  parameter int unsigned GAP_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              odd_sel,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
  localparam logic [7:0] LastGap = 8'(GAP_CYC - 1);

  typedef enum logic [1:0] {StIdle, StShift, StParity, StGap} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        gap_q, gap_d;
  logic              acc_q, acc_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;

  // Outputs are registered: each *_d describes what the state entered at the
  // next edge presents, so ser_out never glitches on the link.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    acc_d         = acc_q;
    ser_out_d     = 1'b0;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          shreg_d       = in_data;
          acc_d         = odd_sel;
          cnt_d         = '0;
          state_d       = StShift;
          ser_out_d     = in_data[0];
          ser_valid_d   = 1'b1;
          frame_start_d = 1'b1;
        end
      end
      StShift: begin
        // The register shifts right, so bit 0 is always the bit on the link.
        acc_d       = acc_q ^ shreg_q[0];
        shreg_d     = shreg_q >> 1;
        ser_valid_d = 1'b1;
        if (cnt_q == LastBit) begin
          state_d      = StParity;
          ser_out_d    = acc_d;
          frame_done_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          ser_out_d = shreg_d[0];
        end
      end
      StParity: begin
        gap_d   = '0;
        state_d = (GAP_CYC > 0) ? StGap : StIdle;
      end
      StGap: begin
        if (gap_q == LastGap) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      cnt_q         <= '0;
      gap_q         <= '0;
      acc_q         <= 1'b0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      acc_q         <= acc_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl: three instances (3-bit/no gap, 3-bit/gap 2,
// 1-bit/no gap) checked against a queue of expected frames.
module tb_parity_frame_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid_a, in_ready_a, odd_a, ser_out_a, ser_valid_a, fs_a, fd_a, busy_a;
  logic [2:0] in_data_a;
  logic       in_valid_b, in_ready_b, odd_b, ser_out_b, ser_valid_b, fs_b, fd_b, busy_b;
  logic [2:0] in_data_b;
  logic       in_valid_c, in_ready_c, odd_c, ser_out_c, ser_valid_c, fs_c, fd_c, busy_c;
  logic [0:0] in_data_c;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  parity_frame_ctrl #(.DATA_W(3), .GAP_CYC(0)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .odd_sel(odd_a), .ser_out(ser_out_a), .ser_valid(ser_valid_a), .frame_start(fs_a),
    .frame_done(fd_a), .busy(busy_a)
  );

  parity_frame_ctrl #(.DATA_W(3), .GAP_CYC(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .odd_sel(odd_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b), .frame_start(fs_b),
    .frame_done(fd_b), .busy(busy_b)
  );

  parity_frame_ctrl #(.DATA_W(1), .GAP_CYC(0)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c),
    .odd_sel(odd_c), .ser_out(ser_out_c), .ser_valid(ser_valid_c), .frame_start(fs_c),
    .frame_done(fd_c), .busy(busy_c)
  );

  task automatic test_reset;
    logic [4:0] outs;
    rst = 1'b1;
    in_valid_a = 1'b0; in_data_a = '0; odd_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; odd_b = 1'b0;
    in_valid_c = 1'b0; in_data_c = '0; odd_c = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {ser_out_a, ser_valid_a, fs_a, fd_a, busy_a};
    n_checks++;
    if (outs !== 5'b0) begin
      n_fail++; $display("FAIL reset_outs_a: got %b expected 00000", outs);
    end
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_a: got %b expected 1", in_ready_a);
    end
    outs = {ser_out_b, ser_valid_b, fs_b, fd_b, busy_b};
    n_checks++;
    if (outs !== 5'b0) begin
      n_fail++; $display("FAIL reset_outs_b: got %b expected 00000", outs);
    end
    n_checks++;
    if (in_ready_b !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_b: got %b expected 1", in_ready_b);
    end
    outs = {ser_out_c, ser_valid_c, fs_c, fd_c, busy_c};
    n_checks++;
    if (outs !== 5'b0) begin
      n_fail++; $display("FAIL reset_outs_c: got %b expected 00000", outs);
    end
    n_checks++;
    if (in_ready_c !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_c: got %b expected 1", in_ready_c);
    end
    #1 rst = 1'b0;
  endtask

  // One frame on instance a; exp_bits = {parity, d[2], d[1], d[0]}.
  task automatic run_frame_a(input logic [2:0] d, input logic odd, input logic [3:0] exp_bits,
                             input string name);
    logic [3:0] got, vld, st, dn, exp;
    exp_q.push_back(exp_bits);
    @(negedge clk);
    in_valid_a = 1'b1; in_data_a = d; odd_a = odd;
    @(posedge clk);
    #1 in_valid_a = 1'b0; in_data_a = ~d; odd_a = ~odd;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got[i] = ser_out_a; vld[i] = ser_valid_a; st[i] = fs_a; dn[i] = fd_a;
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL %s bits: got %b expected %b", name, got, exp);
    end
    n_checks++;
    if (vld !== 4'b1111) begin
      n_fail++; $display("FAIL %s ser_valid: got %b expected 1111", name, vld);
    end
    n_checks++;
    if (st !== 4'b0001) begin
      n_fail++; $display("FAIL %s frame_start: got %b expected 0001", name, st);
    end
    n_checks++;
    if (dn !== 4'b1000) begin
      n_fail++; $display("FAIL %s frame_done: got %b expected 1000", name, dn);
    end
    @(negedge clk);
    n_checks++;
    if ({ser_valid_a, in_ready_a} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s post_idle: got valid=%b ready=%b expected valid=0 ready=1",
               name, ser_valid_a, in_ready_a);
    end
  endtask

  task automatic test_basic;
    run_frame_a(3'b101, 1'b0, 4'b0101, "even_101");
    run_frame_a(3'b101, 1'b1, 4'b1101, "odd_101");
  endtask

  task automatic test_sweep;
    logic [2:0] d;
    logic       o;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 2; j++) begin
        d = 3'(i);
        o = 1'(j);
        run_frame_a(d, o, {^d ^ o, d}, $sformatf("sweep_d%0d_o%0d", i, j));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] f1, f2, e;
    int accept_at = 0;
    int nvld = 0;
    f1 = '0; f2 = '0;
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b1110);
    @(negedge clk);
    in_valid_b = 1'b1; in_data_b = 3'b001; odd_b = 1'b0;
    @(posedge clk);
    #1 in_data_b = 3'b110; odd_b = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ser_valid_b) begin
        if (nvld < 4) f1[nvld] = ser_out_b;
        nvld++;
      end
      if (in_ready_b) begin
        accept_at = c;
        break;
      end
    end
    @(posedge clk);
    #1 in_valid_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      f2[i] = ser_out_b;
    end
    n_checks++;
    if (accept_at != 7) begin
      n_fail++; $display("FAIL b2b_accept_cycle: got T+%0d expected T+7", accept_at);
    end
    n_checks++;
    if (nvld != 4) begin
      n_fail++; $display("FAIL b2b_valid_count: got %0d expected 4", nvld);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (f1 !== e) begin
      n_fail++; $display("FAIL b2b_frame1: got %b expected %b", f1, e);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (f2 !== e) begin
      n_fail++; $display("FAIL b2b_frame2: got %b expected %b", f2, e);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (in_ready_b !== 1'b1) begin
      n_fail++; $display("FAIL b2b_final_ready: got %b expected 1", in_ready_b);
    end
  endtask

  task automatic test_reset_midframe;
    logic [5:0] outs;
    logic       seen;
    @(negedge clk);
    in_valid_a = 1'b1; in_data_a = 3'b011; odd_a = 1'b0;
    @(posedge clk);
    #1 in_valid_a = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ser_valid_a, ser_out_a} !== 2'b11) begin
      n_fail++; $display("FAIL rst_mid_second_bit: got %b expected 11", {ser_valid_a, ser_out_a});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    outs = {ser_out_a, ser_valid_a, fs_a, fd_a, busy_a, in_ready_a};
    n_checks++;
    if (outs !== 6'b000001) begin
      n_fail++; $display("FAIL rst_mid_outs: got %b expected 000001", outs);
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | fd_a | ser_valid_a;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_no_done: got %b expected 0", seen);
    end
    run_frame_a(3'b110, 1'b1, 4'b1110, "after_rst");
  endtask

  task automatic run_frame_c(input logic d, input logic odd, input logic [1:0] exp_bits,
                             input string name);
    logic [1:0] got, vld, st, dn;
    logic [3:0] e;
    exp_q.push_back({2'b00, exp_bits});
    @(negedge clk);
    in_valid_c = 1'b1; in_data_c = d; odd_c = odd;
    @(posedge clk);
    #1 in_valid_c = 1'b0; in_data_c = ~d; odd_c = ~odd;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got[i] = ser_out_c; vld[i] = ser_valid_c; st[i] = fs_c; dn[i] = fd_c;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e[1:0]) begin
      n_fail++; $display("FAIL %s bits: got %b expected %b", name, got, e[1:0]);
    end
    n_checks++;
    if ({vld, st, dn} !== 6'b11_01_10) begin
      n_fail++; $display("FAIL %s flags: got %b expected 110110", name, {vld, st, dn});
    end
    @(negedge clk);
    n_checks++;
    if ({ser_valid_c, in_ready_c} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s length: got valid=%b ready=%b expected valid=0 ready=1",
               name, ser_valid_c, in_ready_c);
    end
  endtask

  task automatic test_width1;
    run_frame_c(1'b1, 1'b0, 2'b11, "w1_d1_even");
    run_frame_c(1'b0, 1'b1, 2'b10, "w1_d0_odd");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_back_to_back();
    test_reset_midframe();
    test_width1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
